// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// stream_mux_rr : packet-atomic round-robin stream multiplexer, 1-cycle latency
// Optional macro STREAM_MUX_STATIC_SEL_EN adds sel_en/sel static selection.
// Rev 1.0
// ============================================================================
module stream_mux_rr #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_CH     = 2,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH-1:0]            in_last,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
`ifdef STREAM_MUX_STATIC_SEL_EN
    input  logic                         sel_en,
    input  logic [SEL_W-1:0]             sel,
`endif
    output logic [SEL_W-1:0]             out_ch
);
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam int               IDX_W     = SEL_W + 1;
    localparam logic [IDX_W-1:0] c_NUM_CH  = IDX_W'(NUM_CH);
    localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(NUM_CH - 1);

    state_t                r_state;
    logic [SEL_W-1:0]      r_rr_ptr;
    logic [SEL_W-1:0]      r_grant;
    logic                  r_hold_ptr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [SEL_W-1:0]      r_out_ch;

    logic                  w_rr_found;
    logic [SEL_W-1:0]      w_rr_ch;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_arb_found;
    logic [SEL_W-1:0]      w_arb_ch;
    logic                  w_use_static;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic                  w_out_free;
    logic                  w_in_xfer;
    logic [SEL_W-1:0]      w_next_ptr;

    // First requester at or above r_rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_ch    = '0;
        w_idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_rr_ptr} + IDX_W'(i);
            if (w_idx >= c_NUM_CH) begin
                w_idx = w_idx - c_NUM_CH;
            end
            if (!w_rr_found && in_valid[w_idx[SEL_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_ch    = w_idx[SEL_W-1:0];
            end
        end
    end

`ifdef STREAM_MUX_STATIC_SEL_EN
    assign w_use_static = sel_en;
    always_comb begin
        if (sel_en) begin
            w_arb_found = in_valid[sel];
            w_arb_ch    = sel;
        end else begin
            w_arb_found = w_rr_found;
            w_arb_ch    = w_rr_ch;
        end
    end
`else
    assign w_use_static = 1'b0;
    assign w_arb_found  = w_rr_found;
    assign w_arb_ch     = w_rr_ch;
`endif

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int g = 0; g < NUM_CH; g++) begin
            if (r_grant == SEL_W'(g)) begin
                w_sel_data  = in_data[g*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = in_valid[g];
                w_sel_last  = in_last[g];
            end
        end
    end

    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_xfer  = (r_state == S_LOCKED) && w_sel_valid && w_out_free;
    assign w_next_ptr = (r_grant == c_LAST_CH) ? '0 : r_grant + 1'b1;

    always_comb begin
        in_ready = '0;
        for (int g = 0; g < NUM_CH; g++) begin
            in_ready[g] = (r_state == S_LOCKED) && (r_grant == SEL_W'(g)) && w_out_free;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_hold_ptr  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arb_found) begin
                        r_grant    <= w_arb_ch;
                        r_hold_ptr <= w_use_static;
                        r_state    <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    // Grant is held until the last beat, regardless of gaps in in_valid.
                    if (w_in_xfer && w_sel_last) begin
                        r_state <= S_IDLE;
                        if (!r_hold_ptr) begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_in_xfer) begin
                r_out_data  <= w_sel_data;
                r_out_last  <= w_sel_last;
                r_out_ch    <= r_grant;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// tb_stream_mux_rr : directed scoreboard bench for stream_mux_rr, NUM_CH=2, DATA_WIDTH=8.
module tb_stream_mux_rr;
    localparam int DW = 8;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]   in_valid;
    logic [NC-1:0]   in_last;
    logic [NC-1:0]   in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic [0:0]      out_ch;
`ifdef STREAM_MUX_STATIC_SEL_EN
    logic            sel_en;
    logic [0:0]      sel;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [9:0] exp_q[$];
    int         beat_cyc[$];
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out   = '0;
    int f0, l0, f1, l1, da, db;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_mux_rr #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
`ifdef STREAM_MUX_STATIC_SEL_EN
        .sel_en    (sel_en),
        .sel       (sel),
`endif
        .out_ch    (out_ch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void sb_push(input logic ch, input logic last, input logic [7:0] d);
        exp_q.push_back({ch, last, d});
    endfunction

    // Presents n beats on channel ch, waiting for each handshake; starts and ends on a negedge.
    task automatic drive_pkt(input int ch, input int n, input logic [7:0] d0, input logic [7:0] step,
                             input int gap, output int first_cyc, output int last_cyc);
        logic acc;
        first_cyc = -1;
        last_cyc  = -1;
        for (int k = 0; k < n; k++) begin
            in_data[ch*DW +: DW] = d0 + 8'(k) * step;
            in_last[ch]  = (k == n - 1);
            in_valid[ch] = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                #1;
                if (in_ready[ch]) begin
                    acc = 1'b1;
                    if (k == 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
                @(negedge clk);
            end
            chk("accept_timeout", 32'(acc), 32'd1);
            in_valid[ch] = 1'b0;
            in_last[ch]  = 1'b0;
            if (k < n - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_out_ch"},    32'(out_ch),    32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    endtask

    // Output monitor: pops the scoreboard on every output handshake, checks hold during stalls.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_hold", 32'({out_ch, out_last, out_data}), 32'(prev_out));
                end
                if (out_valid && out_ready) begin
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e[7:0]));
                        chk("out_last", 32'(out_last), 32'(e[8]));
                        chk("out_ch",   32'(out_ch),   32'(e[9]));
                        beat_cyc.push_back(cyc);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_ch, out_last, out_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 2'b11;
        in_last   = '0;
        in_data   = '0;
`ifdef STREAM_MUX_STATIC_SEL_EN
        sel_en = 1'b0;
        sel    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 3-beat packet on ch0, streamed back to back.
        beat_cyc.delete();
        sb_push(1'b0, 1'b0, 8'h11);
        sb_push(1'b0, 1'b0, 8'h22);
        sb_push(1'b0, 1'b1, 8'h33);
        drive_pkt(0, 3, 8'h11, 8'h11, 0, f0, l0);
        drain();
        chk("pkt3_beats", 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() == 3) begin
            chk("pkt3_gap01", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
            chk("pkt3_gap12", 32'(beat_cyc[2] - beat_cyc[1]), 32'd1);
        end

        // Both channels continuously requesting single-beat packets; pointer now at ch1.
        beat_cyc.delete();
        for (int j = 0; j < 3; j++) begin
            sb_push(1'b1, 1'b1, 8'hB0 + 8'(j));
            sb_push(1'b0, 1'b1, 8'hA0 + 8'(j));
        end
        fork
            for (int j = 0; j < 3; j++) drive_pkt(0, 1, 8'hA0 + 8'(j), 8'h00, 0, da, l0);
            for (int j = 0; j < 3; j++) drive_pkt(1, 1, 8'hB0 + 8'(j), 8'h00, 0, db, l1);
        join
        drain();
        chk("rr_beats", 32'(beat_cyc.size()), 32'd6);
        if (beat_cyc.size() == 6) begin
            for (int i = 1; i < 6; i++) chk("rr_spacing", 32'(beat_cyc[i] - beat_cyc[i-1]), 32'd2);
        end

        // Downstream stall of 4 cycles in the middle of a 4-beat ch1 packet.
        for (int j = 0; j < 4; j++) sb_push(1'b1, (j == 3), 8'hC1 + 8'(j));
        fork
            drive_pkt(1, 4, 8'hC1, 8'h01, 0, f1, l1);
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    #1;
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);

        // ch0 requests while ch1's packet (with input gaps) is in flight.
        sb_push(1'b1, 1'b0, 8'hD1);
        sb_push(1'b1, 1'b0, 8'hD2);
        sb_push(1'b1, 1'b1, 8'hD3);
        sb_push(1'b0, 1'b0, 8'hE1);
        sb_push(1'b0, 1'b1, 8'hE2);
        fork
            drive_pkt(1, 3, 8'hD1, 8'h01, 3, f1, l1);
            begin
                repeat (2) @(negedge clk);
                drive_pkt(0, 2, 8'hE1, 8'h01, 0, f0, l0);
            end
        join
        chk("no_interleave", 32'(f0 > l1), 32'd1);
        drain();

        // Reset asserted while beat 2 of a 4-beat ch1 packet is on the output.
        sb_push(1'b1, 1'b0, 8'h51);
        sb_push(1'b1, 1'b0, 8'h52);
        in_data[15:8] = 8'h51;
        in_last[1]    = 1'b0;
        in_valid[1]   = 1'b1;
        repeat (2) @(negedge clk);
        in_data[15:8] = 8'h52;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        chk("midreset_sb_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_push(1'b0, 1'b1, 8'h61);
        sb_push(1'b1, 1'b1, 8'h71);
        fork
            drive_pkt(0, 1, 8'h61, 8'h00, 0, da, l0);
            drive_pkt(1, 1, 8'h71, 8'h00, 0, db, l1);
        join
        drain();

`ifdef STREAM_MUX_STATIC_SEL_EN
        // Static selection of ch1 while ch0 also requests.
        sel_en = 1'b1;
        sel    = 1'b1;
        in_data[7:0] = 8'h99;
        in_last[0]   = 1'b1;
        in_valid[0]  = 1'b1;
        sb_push(1'b1, 1'b1, 8'h81);
        sb_push(1'b1, 1'b1, 8'h82);
        fork
            begin
                drive_pkt(1, 1, 8'h81, 8'h00, 0, db, l1);
                drive_pkt(1, 1, 8'h82, 8'h00, 0, db, l1);
            end
            for (int s = 0; s < 6; s++) begin
                #1;
                chk("static_ch0_ready", 32'(in_ready[0]), 32'd0);
                @(negedge clk);
            end
        join
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        sel_en = 1'b0;
        drain();
`endif

        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
